// File: rtl/byte_fifo_pkg.sv
// byte_fifo_pkg: shared width constant and pointer-width helper for byte_fifo
package byte_fifo_pkg;

    localparam int BYTE_W = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_fifo_mem.sv
// byte_fifo_mem: DEPTH x WIDTH register array, synchronous write, asynchronous read, no reset
module byte_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/byte_fifo.sv
// byte_fifo: first-word-fall-through valid/ready FIFO with wrap-bit pointers
// optional occupancy output enabled by BYTE_FIFO_LEVEL_EN
module byte_fifo
    import byte_fifo_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BYTE_FIFO_LEVEL_EN
    ,
    output logic [ptr_w(DEPTH)-1:0] level
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    // flags come only from registered pointers, so no in->out combinational path
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef BYTE_FIFO_LEVEL_EN
    assign level = wr_ptr - rd_ptr;
`endif

    byte_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_byte_fifo.sv
// tb_byte_fifo: directed vector table plus corner sequences and a queue-model random run
module tb_byte_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       iv, ir, ov, ordy;
    logic [7:0] din, od;
`ifdef BYTE_FIFO_LEVEL_EN
    logic [3:0] level;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    byte_fifo #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .in_data   (din),
        .out_valid (ov),
        .out_ready (ordy),
        .out_data  (od)
`ifdef BYTE_FIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       eir;
        logic       eov;
        logic [7:0] eod;
        logic [3:0] elv;
    } vec_t;

    vec_t v [10];
    logic [7:0] q [$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", n, a, e);
        end
    endtask

    task automatic chk_lv(input string n, input int e);
`ifdef BYTE_FIFO_LEVEL_EN
        chk(n, 32'(level), 32'(e));
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        iv = 1'b0;
        ordy = 1'b0;
        din = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_ov", ov, 0);
        chk("rst_ir", ir, 1);
        chk_lv("rst_lv", 0);

        // fields: iv, data, out_ready, then expected in_ready, out_valid, out_data, level after the edge
        v[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 4'd1};
        v[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 4'd2};
        v[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 4'd3};
        v[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 4'd2};
        v[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 4'd1};
        v[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
        v[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
        v[7] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 4'd1};
        v[8] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 4'd1};
        v[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv = v[i].iv;
            din = v[i].d;
            ordy = v[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ir", i), ir, v[i].eir);
            chk($sformatf("vec%0d_ov", i), ov, v[i].eov);
            if (v[i].eov) chk($sformatf("vec%0d_od", i), od, v[i].eod);
            chk_lv($sformatf("vec%0d_lv", i), int'(v[i].elv));
        end

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            iv = 1'b1;
            din = 8'(k);
            ordy = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("fill%0d_ir", k), ir, (k < 7) ? 1 : 0);
            chk_lv($sformatf("fill%0d_lv", k), k + 1);
        end
        @(negedge clk);
        din = 8'hFF;
        @(posedge clk);
        #1;
        chk("full_ir", ir, 0);
        chk("full_od", od, 8'h00);
        chk_lv("full_lv", 8);
        @(negedge clk);
        ordy = 1'b1;
        #1;
        chk("full_head", od, 8'h00);
        @(posedge clk);
        #1;
        chk("unfull_ir", ir, 1);
        chk("unfull_od", od, 8'h01);
        chk_lv("unfull_lv", 7);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            iv = 1'b0;
            #1;
            chk($sformatf("drain%0d_od", k), od, k);
        end
        @(posedge clk);
        #1;
        chk("drained_ov", ov, 0);

        @(negedge clk);
        iv = 1'b1;
        ordy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 8'(i);
            @(posedge clk);
            #1;
            chk($sformatf("str%0d_ov", i), ov, 1);
            chk($sformatf("str%0d_od", i), od, i);
            chk_lv($sformatf("str%0d_lv", i), 1);
            @(negedge clk);
        end
        iv = 1'b0;
        @(posedge clk);
        #1;
        chk("str_end_ov", ov, 0);

        q = {};
        for (int n = 0; n < 1000; n++) begin
            logic push, pop;
            @(negedge clk);
            iv = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            #1;
            chk("rnd_ov", ov, q.size() > 0);
            chk("rnd_ir", ir, q.size() < 8);
            if (q.size() > 0) chk("rnd_od", od, q[0]);
            chk_lv("rnd_lv", q.size());
            push = iv && (q.size() < 8);
            pop = ordy && (q.size() > 0);
            @(posedge clk);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(din);
        end

        @(negedge clk);
        reset_n = 1'b0;
        iv = 1'b0;
        ordy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            iv = 1'b1;
            din = 8'(8'h60 + k);
            @(negedge clk);
        end
        iv = 1'b0;
        #1;
        chk("pre_rst_ov", ov, 1);
        chk_lv("pre_rst_lv", 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ov", ov, 0);
        chk("async_rst_ir", ir, 1);
        chk_lv("async_rst_lv", 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ov", ov, 0);
        chk_lv("post_rst_lv", 0);
        iv = 1'b1;
        din = 8'hA5;
        @(posedge clk);
        #1;
        chk("a5_ov", ov, 1);
        chk("a5_od", od, 8'hA5);
        chk_lv("a5_lv", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
